// File: rtl/scan_decoder.sv
// scan_decoder: registered one-hot decoder with DIRECT decode and SCAN sweep modes; ports clk, rst_n, en, mode, in_valid, in, dwell -> op, idx, wrap, busy; SCAN_DECODER_BLANK_EN adds a blank cycle after each scan slot
module scan_decoder #(
  parameter int IN_W = 4,
  parameter int DWELL_W = 8,
  localparam int OUT_W = 1 << IN_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               mode,
  input  logic               in_valid,
  input  logic [IN_W-1:0]    in,
  input  logic [DWELL_W-1:0] dwell,
  output logic [OUT_W-1:0]   op,
  output logic [IN_W-1:0]    idx,
  output logic               wrap,
  output logic               busy
);
`ifdef SCAN_DECODER_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;
  state_t state, state_n;
  logic [DWELL_W-1:0] cnt, cnt_n, dw_s, dw_s_n;
  logic [OUT_W-1:0] op_n;
  logic [IN_W-1:0] idx_n;
  logic wrap_n, blank, blank_n, slot_end, advance;
  always_comb begin
    state_n = !en ? IDLE : mode ? SCAN : DIRECT;
    slot_end = !blank && cnt == dw_s;
    advance = blank || (slot_end && !BLANK);
    op_n = op;
    idx_n = idx;
    wrap_n = 1'b0;
    cnt_n = cnt;
    dw_s_n = dw_s;
    blank_n = 1'b0;
    case (state_n)
      DIRECT: begin
        cnt_n = '0;
        if (in_valid) begin
          op_n = OUT_W'(1) << in;
          idx_n = in;
        end
      end
      SCAN: begin
        if (state != SCAN) begin
          op_n = OUT_W'(1);
          idx_n = '0;
          cnt_n = '0;
          dw_s_n = dwell;
        end else if (advance) begin
          idx_n = idx + 1'b1;
          op_n = OUT_W'(1) << (idx + 1'b1);
          wrap_n = &idx;
          cnt_n = '0;
          dw_s_n = dwell;
        end else if (slot_end) begin
          blank_n = 1'b1;
          op_n = '0;
          cnt_n = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        op_n = '0;
        cnt_n = '0;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      op <= '0;
      idx <= '0;
      wrap <= 1'b0;
      busy <= 1'b0;
      cnt <= '0;
      dw_s <= '0;
      blank <= 1'b0;
    end else begin
      state <= state_n;
      op <= op_n;
      idx <= idx_n;
      wrap <= wrap_n;
      busy <= state_n == SCAN;
      cnt <= cnt_n;
      dw_s <= dw_s_n;
      blank <= blank_n;
    end
  end
endmodule

// File: tb/tb_scan_decoder.sv
// tb_scan_decoder: table vectors, hand sequences and randomized checks of scan_decoder against a slot/phase reference model
module tb_scan_decoder;
  localparam int IN_W = 4;
  localparam int DWELL_W = 8;
  localparam int OUT_W = 16;
`ifdef SCAN_DECODER_BLANK_EN
  localparam int B = 1;
`else
  localparam int B = 0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, mode = 1'b0, in_valid = 1'b0;
  logic [IN_W-1:0] in = '0;
  logic [DWELL_W-1:0] dwell = '0;
  logic [OUT_W-1:0] op;
  logic [IN_W-1:0] idx;
  logic wrap, busy;
  always #5 clk = ~clk;
  scan_decoder #(.IN_W(IN_W), .DWELL_W(DWELL_W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .in_valid(in_valid),
    .in(in), .dwell(dwell), .op(op), .idx(idx), .wrap(wrap), .busy(busy)
  );
  int errors = 0, checks = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // reference model: st 0=idle 1=direct 2=scan; scan tracked as slot number plus phase within a slot of length L
  int m_st, m_slot, m_p, m_len;
  logic [OUT_W-1:0] m_op;
  logic [IN_W-1:0] m_idx;
  logic m_wrap, m_busy;
  task automatic model_reset();
    m_st = 0; m_slot = 0; m_p = 0; m_len = 1;
    m_op = '0; m_idx = '0; m_wrap = 0; m_busy = 0;
  endtask
  task automatic model_edge();
    int ns;
    ns = !en ? 0 : mode ? 2 : 1;
    m_wrap = 0;
    if (ns == 0) m_op = '0;
    else if (ns == 1) begin
      if (in_valid) begin
        m_idx = in;
        m_op = 16'd1 << in;
      end
    end else begin
      if (m_st != 2) begin
        m_slot = 0; m_p = 0; m_len = int'(dwell) + 1 + B;
      end else begin
        m_p++;
        if (m_p == m_len) begin
          m_p = 0;
          m_slot = (m_slot + 1) % OUT_W;
          m_len = int'(dwell) + 1 + B;
          m_wrap = (m_slot == 0);
        end
      end
      m_idx = IN_W'(m_slot);
      m_op = (B == 1 && m_p == m_len - 1) ? '0 : 16'd1 << m_slot;
    end
    m_busy = (ns == 2);
    m_st = ns;
  endtask
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask
  task automatic check_model(input string tag);
    chk({tag, " op"}, 32'(op), 32'(m_op));
    chk({tag, " idx"}, 32'(idx), 32'(m_idx));
    chk({tag, " wrap"}, 32'(wrap), 32'(m_wrap));
    chk({tag, " busy"}, 32'(busy), 32'(m_busy));
  endtask
  task automatic set_in(input logic e, input logic m, input logic v, input logic [3:0] i, input logic [7:0] d);
    en = e; mode = m; in_valid = v; in = i; dwell = d;
  endtask
  task automatic scan_restart(input logic [7:0] d);
    set_in(1, 0, 0, 0, d);
    step();
    mode = 1;
    step();
    check_model("restart");
  endtask
  typedef struct {
    logic e, m, v;
    logic [3:0] i;
    logic [7:0] d;
    logic [15:0] eop;
    logic [3:0] eidx;
    logic ewrap, ebusy;
  } vec_t;
  vec_t vecs[$];
  initial begin
    int c5, c6, w0, w1, k;
    bit found;
    model_reset();
    vecs.push_back('{1, 0, 0, 4'd3, 8'd0, 16'h0000, 4'd0, 0, 0});
    for (int i = 0; i < 16; i++) begin
      vecs.push_back('{1, 0, 1, 4'(i), 8'd0, 16'd1 << i, 4'(i), 0, 0});
      vecs.push_back('{1, 0, 0, 4'(~i), 8'd0, 16'd1 << i, 4'(i), 0, 0});
    end
    vecs.push_back('{0, 0, 1, 4'd2, 8'd0, 16'h0000, 4'd15, 0, 0});
    vecs.push_back('{1, 0, 0, 4'd2, 8'd0, 16'h0000, 4'd15, 0, 0});
    vecs.push_back('{1, 1, 1, 4'd9, 8'd0, 16'h0001, 4'd0, 0, 1});
    vecs.push_back('{1, 1, 0, 4'd9, 8'd0, B ? 16'h0000 : 16'h0002, B ? 4'd0 : 4'd1, 0, 1});
    vecs.push_back('{1, 0, 0, 4'd9, 8'd0, B ? 16'h0000 : 16'h0002, B ? 4'd0 : 4'd1, 0, 0});
    vecs.push_back('{1, 0, 1, 4'd7, 8'd0, 16'h0080, 4'd7, 0, 0});
    #2;
    chk("reset op", 32'(op), 0);
    chk("reset idx", 32'(idx), 0);
    chk("reset wrap", 32'(wrap), 0);
    chk("reset busy", 32'(busy), 0);
    #10 rst_n = 1;
    foreach (vecs[n]) begin
      set_in(vecs[n].e, vecs[n].m, vecs[n].v, vecs[n].i, vecs[n].d);
      step();
      chk($sformatf("vec%0d op", n), 32'(op), 32'(vecs[n].eop));
      chk($sformatf("vec%0d idx", n), 32'(idx), 32'(vecs[n].eidx));
      chk($sformatf("vec%0d wrap", n), 32'(wrap), 32'(vecs[n].ewrap));
      chk($sformatf("vec%0d busy", n), 32'(busy), 32'(vecs[n].ebusy));
    end
    // dwell 0 sweep: first wrap lands one full sweep after entry
    scan_restart(0);
    w0 = -1;
    for (k = 1; k < 40 * (1 + B); k++) begin
      step();
      check_model("sweep0");
      if (wrap && w0 < 0) w0 = k;
    end
    chk("sweep0 first wrap", 32'(w0), 32'(16 * (1 + B)));
    // dwell 3: wrap period
    scan_restart(3);
    w0 = -1; w1 = -1;
    for (k = 1; k < 300 && w1 < 0; k++) begin
      step();
      check_model("dwell3");
      if (wrap) begin
        if (w0 < 0) w0 = k;
        else w1 = k;
      end
    end
    chk("dwell3 wrap period", 32'(w1 - w0), 32'(16 * (4 + B)));
    // dwell change mid-slot 5 takes effect at slot 6
    scan_restart(3);
    c5 = 0; c6 = 0; found = 0;
    for (k = 0; k < 200 && !found; k++) begin
      step();
      check_model("dwchg");
      if (op != 0 && idx == 5) c5++;
      if (op != 0 && idx == 6) c6++;
      if (c5 == 2) dwell = 1;
      if (idx == 7) found = 1;
    end
    chk("dwchg reached", 32'(found), 1);
    chk("dwchg slot5 len", 32'(c5), 4);
    chk("dwchg slot6 len", 32'(c6), 2);
    // drop en at idx 9, re-enable restarts at slot 0
    scan_restart(0);
    found = 0;
    for (k = 0; k < 100 && !found; k++) begin
      if (op != 0 && idx == 9) found = 1;
      else begin
        step();
        check_model("to9");
      end
    end
    chk("to9 reached", 32'(found), 1);
    en = 0;
    step();
    chk("endrop op", 32'(op), 0);
    chk("endrop busy", 32'(busy), 0);
    en = 1;
    step();
    chk("reen op", 32'(op), 1);
    chk("reen idx", 32'(idx), 0);
    chk("reen wrap", 32'(wrap), 0);
    // switch to DIRECT at idx 6 freezes, then decode in=2
    scan_restart(0);
    found = 0;
    for (k = 0; k < 100 && !found; k++) begin
      if (op != 0 && idx == 6) found = 1;
      else begin
        step();
        check_model("to6");
      end
    end
    chk("to6 reached", 32'(found), 1);
    mode = 0;
    step();
    chk("freeze op", 32'(op), 32'h0040);
    chk("freeze idx", 32'(idx), 6);
    chk("freeze busy", 32'(busy), 0);
    in_valid = 1; in = 2;
    step();
    chk("direct2 op", 32'(op), 32'h0004);
    in_valid = 0;
    // asynchronous reset between edges mid-scan
    scan_restart(0);
    for (int j = 0; j < 5; j++) step();
    #2 rst_n = 0;
    #1;
    chk("async op", 32'(op), 0);
    chk("async idx", 32'(idx), 0);
    chk("async busy", 32'(busy), 0);
    model_reset();
    @(negedge clk) rst_n = 1;
    // randomized traffic
    for (int j = 0; j < 3000; j++) begin
      en = ($urandom % 25) != 0;
      if ($urandom % 30 == 0) mode = ~mode;
      in_valid = $urandom % 2;
      in = 4'($urandom);
      if ($urandom % 12 == 0) dwell = 8'($urandom % 4);
      step();
      check_model("rand");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
